// File: rtl/spike_rec_pkg.sv
// Shared constants for the spike pipe recorder: word geometry and drop-counter limits.
package spike_rec_pkg;

   localparam int WORD_W        = 16;
   localparam int BITS_PER_WORD = 16;
   localparam int BIT_CNT_W     = $clog2(BITS_PER_WORD);
   localparam int DROP_CNT_W    = 16;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/spike_rec_fifo.sv
// First-word-fall-through FIFO. Storage is a RAM with a registered head word;
// a word pushed into an empty (or draining) FIFO bypasses the RAM into the head register.
module spike_rec_fifo
   import spike_rec_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  reset_global,
   input  logic                  push,
   input  logic [WORD_W-1:0]     din,
   input  logic                  pop,
   output logic [WORD_W-1:0]     dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] PTR_ZERO = '0;

   logic [WORD_W-1:0]   mem_q [2**DEPTH_LOG2];
   logic [DEPTH_LOG2:0] wr_q, wr_d;
   logic [DEPTH_LOG2:0] rd_q, rd_d;
   logic [WORD_W-1:0]   dout_q, dout_d;
   logic                push_ok, pop_ok;

   assign count   = wr_q - rd_q;
   assign empty   = (wr_q == rd_q);
   assign full    = (count == FULL_LVL);
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push_ok = push & (~full | pop_ok);
   assign dout    = dout_q;

   // Next pointers and next head word (hold the last head while the FIFO is empty).
   always_comb begin
      wr_d   = wr_q + (push_ok ? PTR_ZERO + 1'b1 : PTR_ZERO);
      rd_d   = rd_q + (pop_ok  ? PTR_ZERO + 1'b1 : PTR_ZERO);
      dout_d = dout_q;
      if (rd_d != wr_d) begin
         if (rd_d == wr_q) dout_d = din;
         else              dout_d = mem_q[rd_d[DEPTH_LOG2-1:0]];
      end
   end

   // RAM write port.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[DEPTH_LOG2-1:0]] <= din;
   end

   // Pointers and head register.
   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
         wr_q   <= '0;
         rd_q   <= '0;
         dout_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         dout_q <= dout_d;
      end
   end

endmodule

// File: rtl/spike_pipe_recorder.sv
// Spike recorder: synchronises sample_clk/spike_in onto ti_clk, packs 16 samples per
// word (oldest in bit 15) and buffers words for an okBTPipeOut endpoint.
// Optional macro SPIKE_PIPE_REC_DROP_CNT_EN adds a saturating drop_cnt output.
module spike_pipe_recorder
   import spike_rec_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int BLOCK_WORDS = 256,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_global,
   input  logic                  sample_clk,
   input  logic                  spike_in,
   input  logic                  enable,
   input  logic                  ep_read,
   output logic [WORD_W-1:0]     ep_datain,
   output logic                  ep_ready,
   output logic [DEPTH_LOG2:0]   fill_level,
   output logic                  overflow_sticky,
   output logic                  underflow_sticky
`ifdef SPIKE_PIPE_REC_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   localparam logic [DEPTH_LOG2:0]  BLOCK_LVL = (DEPTH_LOG2+1)'(BLOCK_WORDS);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(BITS_PER_WORD-1);
   localparam logic [BIT_CNT_W-1:0] CNT_ONE   = BIT_CNT_W'(1);

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] spike_sync_q;
   logic                   sclk_prev_q;
   logic                   tick_q;
   logic                   sclk_s, spike_s;

   logic [WORD_W-2:0]      sr_q, sr_d;
   logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   push;
   logic [WORD_W-1:0]      word;

   logic                   fifo_full, fifo_empty;
   logic [DEPTH_LOG2:0]    fifo_count;
   logic                   ready_q;
   logic                   ovf_q, udf_q;
   logic                   drop;

   assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
   assign spike_s = spike_sync_q[SYNC_STAGES-1];

   // Synchronisers and rising-edge detector on the sample clock.
   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
         sclk_sync_q  <= '0;
         spike_sync_q <= '0;
         sclk_prev_q  <= 1'b0;
         tick_q       <= 1'b0;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sample_clk};
         spike_sync_q <= {spike_sync_q[SYNC_STAGES-2:0], spike_in};
         sclk_prev_q  <= sclk_s;
         tick_q       <= sclk_s & ~sclk_prev_q;
      end
   end

   // Packer: shift one sample per tick, push on the 16th; disabling discards a partial word.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      push  = 1'b0;
      word  = {sr_q, spike_s};
      if (!enable) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (tick_q) begin
         sr_d  = {sr_q[WORD_W-3:0], spike_s};
         cnt_d = cnt_q + CNT_ONE;
         push  = (cnt_q == LAST_BIT);
      end
   end

   // Packer state.
   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   spike_rec_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk          (clk),
      .reset_global (reset_global),
      .push         (push),
      .din          (word),
      .pop          (ep_read),
      .dout         (ep_datain),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .count        (fifo_count)
   );

   // A full FIFO only rejects the push when no pop frees a slot in the same cycle.
   assign drop = push & fifo_full & ~ep_read;

   // Registered block-ready flag and sticky error flags.
   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         ready_q <= (fifo_count >= BLOCK_LVL);
         if (drop)                  ovf_q <= 1'b1;
         if (ep_read && fifo_empty) udf_q <= 1'b1;
      end
   end

   assign ep_ready         = ready_q;
   assign fill_level       = fifo_count;
   assign overflow_sticky  = ovf_q;
   assign underflow_sticky = udf_q;

`ifdef SPIKE_PIPE_REC_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q;

   // Saturating count of dropped words.
   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global)                            drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != DROP_CNT_MAX) drop_cnt_q <= drop_cnt_q + 1'b1;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_pipe_recorder.sv
// Scoreboard bench for spike_pipe_recorder: a bit-level packing model pushes expected
// words into a queue as ticks are driven; reads pop and compare against ep_datain.
module tb_spike_pipe_recorder;

   localparam int DL    = 10;
   localparam int BW    = 256;
   localparam int SS    = 2;
   localparam int DEPTH = 1 << DL;

   logic          clk = 1'b0;
   logic          reset_global;
   logic          sample_clk;
   logic          spike_in;
   logic          enable;
   logic          ep_read;
   logic [15:0]   ep_datain;
   logic          ep_ready;
   logic [DL:0]   fill_level;
   logic          overflow_sticky;
   logic          underflow_sticky;
`ifdef SPIKE_PIPE_REC_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   int            n_checks = 0;
   int            n_err    = 0;
   logic [15:0]   exp_q[$];
   logic [14:0]   m_sr;
   int            m_cnt;
   int            m_drops;
   int            cyc = 0;
   int            fill_cyc, rdy_cyc, low_cyc, nrdy_cyc;
   bit            mon_rise, mon_fall;

   spike_pipe_recorder #(
      .DEPTH_LOG2  (DL),
      .BLOCK_WORDS (BW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk              (clk),
      .reset_global     (reset_global),
      .sample_clk       (sample_clk),
      .spike_in         (spike_in),
      .enable           (enable),
      .ep_read          (ep_read),
      .ep_datain        (ep_datain),
      .ep_ready         (ep_ready),
      .fill_level       (fill_level),
      .overflow_sticky  (overflow_sticky),
      .underflow_sticky (underflow_sticky)
`ifdef SPIKE_PIPE_REC_DROP_CNT_EN
      ,
      .drop_cnt         (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Records when fill_level crosses BLOCK_WORDS and when ep_ready follows.
   always @(negedge clk) begin
      if (mon_rise && fill_cyc < 0 && fill_level >= BW) fill_cyc = cyc;
      if (mon_rise && rdy_cyc  < 0 && ep_ready)         rdy_cyc  = cyc;
      if (mon_fall && low_cyc  < 0 && fill_level < BW)  low_cyc  = cyc;
      if (mon_fall && nrdy_cyc < 0 && !ep_ready)        nrdy_cyc = cyc;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_sr  = '0;
      m_cnt = 0;
   endtask

   // One sample tick: sample_clk high for two clk cycles, low for one.
   task automatic tick(input logic v);
      @(negedge clk);
      spike_in   = v;
      sample_clk = 1'b1;
      if (enable) begin
         if (m_cnt == 15) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_sr, v});
            else                      m_drops++;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
         m_sr = {m_sr[13:0], v};
      end
      @(negedge clk);
      @(negedge clk);
      sample_clk = 1'b0;
   endtask

   task automatic settle();
      repeat (8) @(negedge clk);
   endtask

   task automatic read_n(input int n);
      logic [15:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) e = 16'hxxxx;
         else                   e = exp_q.pop_front();
         chk("read_word", {16'h0, ep_datain}, {16'h0, e});
         ep_read = 1'b1;
      end
      @(negedge clk);
      ep_read = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_datain"}, {16'h0, ep_datain}, 32'h0);
      chk({tag, "_ready"},  {31'h0, ep_ready}, 32'h0);
      chk({tag, "_fill"},   {21'h0, fill_level}, 32'h0);
      chk({tag, "_ovf"},    {31'h0, overflow_sticky}, 32'h0);
      chk({tag, "_udf"},    {31'h0, underflow_sticky}, 32'h0);
`ifdef SPIKE_PIPE_REC_DROP_CNT_EN
      chk({tag, "_drops"},  {16'h0, drop_cnt}, 32'h0);
`endif
   endtask

   initial begin
      reset_global = 1'b1;
      sample_clk   = 1'b0;
      spike_in     = 1'b0;
      enable       = 1'b0;
      ep_read      = 1'b0;
      mon_rise     = 1'b0;
      mon_fall     = 1'b0;
      fill_cyc = -1; rdy_cyc = -1; low_cyc = -1; nrdy_cyc = -1;
      m_drops      = 0;
      model_clear();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_global = 1'b0;
      enable       = 1'b1;
      repeat (2) @(negedge clk);

      // Read while empty.
      ep_read = 1'b1;
      @(negedge clk);
      ep_read = 1'b0;
      @(negedge clk);
      chk("udf_set",    {31'h0, underflow_sticky}, 32'h1);
      chk("udf_datain", {16'h0, ep_datain}, 32'h0);
      chk("udf_fill",   {21'h0, fill_level}, 32'h0);
      chk("udf_ovf",    {31'h0, overflow_sticky}, 32'h0);

      // Alternating spikes -> two AAAA words.
      for (int i = 0; i < 32; i++) tick((i % 2) == 0);
      settle();
      chk("alt_fill",  {21'h0, fill_level}, 32'd2);
      chk("alt_ready", {31'h0, ep_ready}, 32'h0);
      read_n(2);
      chk("alt_drain", {21'h0, fill_level}, 32'h0);

      // Partial word discarded by disabling.
      for (int i = 0; i < 7; i++) tick(1'b0);
      settle();
      enable = 1'b0;
      model_clear();
      settle();
      enable = 1'b1;
      for (int i = 0; i < 16; i++) tick(1'b1);
      settle();
      chk("en_fill", {21'h0, fill_level}, 32'd1);
      read_n(1);
      chk("en_drain", {21'h0, fill_level}, 32'h0);
      chk("en_hold",  {16'h0, ep_datain}, 32'hFFFF);

      // Fill one block, then overflow.
      mon_rise = 1'b1;
      for (int i = 0; i < 4096; i++) tick(1'b1);
      settle();
      chk("blk_fill",    {21'h0, fill_level}, 32'd256);
      chk("blk_ready",   {31'h0, ep_ready}, 32'h1);
      chk("blk_rise_lat", rdy_cyc - fill_cyc, 32'd1);
      chk("blk_no_ovf",  {31'h0, overflow_sticky}, 32'h0);
      for (int i = 0; i < 13312; i++) tick(1'b1);
      settle();
      chk("ovf_fill",  {21'h0, fill_level}, DEPTH);
      chk("ovf_set",   {31'h0, overflow_sticky}, 32'h1);
`ifdef SPIKE_PIPE_REC_DROP_CNT_EN
      chk("ovf_drops", {16'h0, drop_cnt}, m_drops);
`endif
      mon_fall = 1'b1;
      read_n(DEPTH);
      @(negedge clk);
      chk("drain_fill",     {21'h0, fill_level}, 32'h0);
      chk("drain_ready",    {31'h0, ep_ready}, 32'h0);
      chk("drain_fall_lat", nrdy_cyc - low_cyc, 32'd1);

      // Reset mid-word with five words buffered.
      for (int i = 0; i < 85; i++) tick(1'b1);
      settle();
      chk("mid_fill", {21'h0, fill_level}, 32'd5);
      @(negedge clk);
      reset_global = 1'b1;
      exp_q.delete();
      model_clear();
      @(negedge clk);
      chk_all_zero("midrst");
      reset_global = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) tick((i % 2) == 1);
      settle();
      chk("post_fill", {21'h0, fill_level}, 32'd1);
      read_n(1);
      chk("post_drain", {21'h0, fill_level}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
